// File: rtl/locker_pkg.sv
// Shared types and constants for the serial password lock front-end and core.
package locker_pkg;

    localparam int CODE_W = 4;

    // Defaults assume a 100 MHz system clock: 10 ms debounce, 5 s inactivity abort.
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_TIMEOUT_CYCLES  = 500_000_000;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        ABORT
    } entry_state_t;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser plus stable-level debouncer with a one-cycle rising-edge pulse.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic in,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    // The counter only runs while a level change is pending, so any glitch back to
    // the current level restarts the stability window from zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], in};
            rise_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= sync_q[1];
                rise_q  <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/code_entry.sv
// Lock front-end: debounced enter button, per-press code capture, digit framing
// with frozen mode and an inactivity abort for stale partial frames.
module code_entry
    import locker_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int DIGITS          = 4,
    localparam int IDX_W          = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [CODE_W-1:0] code_raw,
    input  logic              btn_raw,
    input  logic              mode_raw,
    output logic [CODE_W-1:0] code,
    output logic              step,
    output logic              mode,
    output logic [IDX_W-1:0]  digit_idx,
    output logic              frame_done,
    output logic              abort
);

    localparam int TIM_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIM_W-1:0] TIM_MAX  = TIM_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CODE_W-1:0] code_s1, code_s2;
    logic              mode_s1, mode_s2;
    logic              btn_level, btn_rise, press;

    entry_state_t      state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              step_q, step_d;
    logic              mode_q, mode_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic              abort_q, abort_d;
    logic [TIM_W-1:0]  timer_q, timer_d;

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .CLK   (CLK),
        .RST_N (RST_N),
        .in    (btn_raw),
        .level (btn_level),
        .rise  (btn_rise)
    );

    assign press = btn_rise && btn_level;

    // Code bits may skew across the synchroniser; they are only consumed on a press.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            code_s1 <= '0;
            code_s2 <= '0;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
        end else begin
            code_s1 <= code_raw;
            code_s2 <= code_s1;
            mode_s1 <= mode_raw;
            mode_s2 <= mode_s1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            code_q  <= '0;
            step_q  <= 1'b0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            timer_q <= timer_d;
        end
    end

    // A press always takes priority over timer expiry; a press seen during ABORT is dropped.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        step_d  = 1'b0;
        mode_d  = mode_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        timer_d = '0;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (press) begin
                    code_d  = code_s2;
                    mode_d  = mode_s2;
                    step_d  = 1'b1;
                    idx_d   = IDX_W'(1);
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (press) begin
                    code_d = code_s2;
                    step_d = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (timer_q == TIM_MAX) begin
                    abort_d = 1'b1;
                    idx_d   = '0;
                    state_d = ABORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ABORT: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign code       = code_q;
    assign step       = step_q;
    assign mode       = mode_q;
    assign digit_idx  = idx_q;
    assign frame_done = done_q;
    assign abort      = abort_q;

endmodule
